axis_match_monitor: RTL and testbench
=====================================

# axis_match_monitor

Passive, parametrised AXI-Stream packet checker that taps a stream (e.g. the CMAC TX side of the shell) and classifies the first beat of every packet against up to NUM_PAT masked expected patterns. It counts matches per pattern, counts unmatched packets, and declares pass when every enabled pattern reaches its expected count, or fail on timeout. It generalises the single fixed-value compare into a reusable, synthesizable multi-pattern, counted, time-bounded checker for benches and on-chip self-test.

## Interface
- DATA_W, 512, stream data width in bits (multiple of 8)
- NUM_PAT, 4, number of pattern slots (1..16)
- CNT_W, 16, width of every packet counter
- TMO_W, 24, width of the timeout counter
- axis_aclk  in  1  sole clock
- axis_rst  in  1  asynchronous, active-high reset
- cfg_wr  in  1  write pattern slot cfg_idx (honoured only in IDLE or DONE)
- cfg_idx  in  $clog2(NUM_PAT)  slot index
- cfg_en  in  1  slot enable
- cfg_value  in  DATA_W  expected first-beat data
- cfg_mask  in  DATA_W  1 = bit compared
- cfg_expect  in  CNT_W  matches required for the slot
- arm  in  1  start a check run (pulse)
- abort  in  1  return to IDLE
- tmo_cycles  in  TMO_W  run budget, sampled on arm
- mon_tdata  in  DATA_W  tapped data
- mon_tvalid  in  1  tapped valid
- mon_tready  in  1  tapped ready
- mon_tlast  in  1  tapped last
- match_cnt  out  NUM_PAT*CNT_W  per-slot match counts, slot i at [i*CNT_W +: CNT_W]
- unmatched_cnt  out  CNT_W  first beats that matched no enabled slot
- busy  out  1  state is ARMED
- done  out  1  state is DONE
- pass  out  1  valid when done
- timeout  out  1  valid when done

## Operation
- Beat accepted = mon_tvalid & mon_tready. The block never drives the stream.
- SOP tracker: sop=1 after reset. An accepted beat with tlast sets sop=1; without tlast it clears sop. The tracker runs in every state.
- States: IDLE, ARMED, DONE.
  - IDLE to ARMED on arm: clear all counters, load the timer with tmo_cycles, clear pass and timeout.
  - ARMED to DONE with pass=1 when every enabled slot has match_cnt >= cfg_expect.
  - ARMED to DONE with timeout=1, pass=0 when the timer reaches 0.
  - DONE to ARMED on arm, acting as a restart.
  - Any state to IDLE on abort. Counters are held.
- arm while ARMED is ignored. abort and arm in the same cycle: abort wins.
- Slot i matches when ((mon_tdata ^ value_i) & mask_i) == 0 and en_i. Only SOP beats are compared.
- One SOP beat may match several slots. Every matching slot increments. If none match, unmatched_cnt increments.
- Counters saturate at all-ones. Counting happens only in ARMED.
- Run with zero enabled slots: pass on the first evaluation cycle after arm.
- Slot with cfg_expect=0 is satisfied immediately.
- cfg_wr during ARMED is dropped silently. Slot storage is not cleared by arm, only by reset.

## Timing
- Compare pipeline has two stages:
  - Stage 1 registers the match vector and an sop_hit flag from the accepted beat.
  - Stage 2 updates the counters.
  - Counters reflect a beat 2 cycles after acceptance.
  - The completion check uses the registered counters, so done rises 3 cycles after the satisfying beat.
- Beats in flight at the moment of DONE or abort are discarded and not counted.
- Timer: decrements once per ARMED cycle. tmo_cycles=0 times out on the first ARMED cycle.
- Completion and timer expiry in the same cycle: pass wins, timeout=0.
- Reset values: state IDLE; all counters 0; busy, done, pass, timeout all 0; sop=1; all slots disabled with value, mask and expect 0.
- Reset mid-packet: sop=1. The next accepted beat is treated as SOP.

## Structure
- Package axis_match_monitor_pkg holds:
  - state enum (IDLE, ARMED, DONE)
  - slot struct (en, value, mask, expect)
  - counter saturation helper function
- Sub-module axis_match_slot (one per slot, generate loop): owns the registered compare and the saturating counter, and exports match_cnt and a satisfied flag.
- The top level holds the FSM, timer, SOP tracker, unmatched counter and AND-reduction of satisfied flags.

## Test plan
- Slot0 value=SUB packet, full mask, expect=1; arm; send SUB single-beat packet. Required: match_cnt[0]=1, done=1, pass=1, done rising 3 cycles after the beat.
- Slots 0 and 1 (SUB and ADD, expect 1 each); send ADD then SUB, each tlast. Required: pass only after the second packet; unmatched_cnt=0.
- 3-beat packet whose second beat equals the slot0 value. Required: no match, unmatched_cnt=1.
- tmo_cycles=100 with no traffic. Required: done=1, timeout=1, pass=0 at cycle 100 after arm; satisfying beat on the expiry cycle gives pass=1, timeout=0.
- Mask ignores the bytes carrying the result field; vary those bytes. Required: every packet matches. Also drive mon_tready=0 with mon_tvalid=1. Required: no counting.
- Reset asserted mid-packet and abort during ARMED. Required: all outputs at reset values; counters held after abort; cfg_wr in ARMED has no effect.

Source files
------------

// File: rtl/axis_match_monitor_pkg.sv
// Shared definitions for the AXI-Stream first-beat match monitor:
// state encoding, default-width slot record and the saturating increment.
package axis_match_monitor_pkg;

   // state | meaning
   // IDLE  | waiting for arm, counters held, slot writes accepted
   // ARMED | classifying first beats, timer running
   // DONE  | run finished, pass/timeout valid, slot writes accepted
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_ARMED = 2'd1;
   localparam state_t ST_DONE  = 2'd2;

   // Slot record at the default widths, for software and bench tooling.
   localparam int SLOT_DATA_W = 512;
   localparam int SLOT_CNT_W  = 16;

   typedef struct packed {
      logic                   en;
      logic [SLOT_DATA_W-1:0] value;
      logic [SLOT_DATA_W-1:0] mask;
      logic [SLOT_CNT_W-1:0]  expect_cnt;
   } slot_cfg_t;

   // Increment that sticks at all-ones of a counter 'width' bits wide (width <= 32).
   function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int unsigned width);
      logic [31:0] top;
      top = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      sat_inc = (cnt >= top) ? top : cnt + 32'd1;
   endfunction

endpackage

// File: rtl/axis_match_slot.sv
// One pattern slot: stored configuration, registered masked compare of the
// first beat (stage 1) and a saturating match counter (stage 2).
module axis_match_slot
   import axis_match_monitor_pkg::*;
#(
   parameter int DATA_W = 512,
   parameter int CNT_W  = 16
) (
   input  logic              axis_aclk,
   input  logic              axis_rst,
   input  logic              cfg_wr,
   input  logic              cfg_en,
   input  logic [DATA_W-1:0] cfg_value,
   input  logic [DATA_W-1:0] cfg_mask,
   input  logic [CNT_W-1:0]  cfg_expect,
   input  logic [DATA_W-1:0] tdata,
   input  logic              sample,
   input  logic              run,
   input  logic              clear,
   output logic              hit,
   output logic [CNT_W-1:0]  match_cnt,
   output logic              satisfied
);

   logic              en_q;
   logic [DATA_W-1:0] value_q;
   logic [DATA_W-1:0] mask_q;
   logic [CNT_W-1:0]  expect_q;

   // Slot storage; only reset clears it, arm leaves it alone.
   always_ff @(posedge axis_aclk or posedge axis_rst) begin
      if (axis_rst) begin
         en_q     <= 1'b0;
         value_q  <= '0;
         mask_q   <= '0;
         expect_q <= '0;
      end else if (cfg_wr) begin
         en_q     <= cfg_en;
         value_q  <= cfg_value;
         mask_q   <= cfg_mask;
         expect_q <= cfg_expect;
      end
   end

   // Stage 1: register the compare; sample is low whenever the run is not continuing, which flushes it.
   always_ff @(posedge axis_aclk or posedge axis_rst) begin
      if (axis_rst) hit <= 1'b0;
      else          hit <= sample && en_q && (((tdata ^ value_q) & mask_q) == '0);
   end

   // Stage 2: saturating count, frozen once the run stops.
   always_ff @(posedge axis_aclk or posedge axis_rst) begin
      if (axis_rst)        match_cnt <= '0;
      else if (clear)      match_cnt <= '0;
      else if (run && hit) match_cnt <= CNT_W'(sat_inc(32'(match_cnt), CNT_W));
   end

   assign satisfied = !en_q || (match_cnt >= expect_q);

endmodule

// File: rtl/axis_match_monitor.sv
// Passive AXI-Stream checker: classifies the first beat of each packet
// against NUM_PAT masked patterns, counts per-slot and unmatched packets,
// and ends a run with pass (all enabled slots satisfied) or timeout.
module axis_match_monitor
   import axis_match_monitor_pkg::*;
#(
   parameter int DATA_W  = 512,
   parameter int NUM_PAT = 4,
   parameter int CNT_W   = 16,
   parameter int TMO_W   = 24,
   localparam int IDX_W  = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1
) (
   input  logic                     axis_aclk,
   input  logic                     axis_rst,
   input  logic                     cfg_wr,
   input  logic [IDX_W-1:0]         cfg_idx,
   input  logic                     cfg_en,
   input  logic [DATA_W-1:0]        cfg_value,
   input  logic [DATA_W-1:0]        cfg_mask,
   input  logic [CNT_W-1:0]         cfg_expect,
   input  logic                     arm,
   input  logic                     abort,
   input  logic [TMO_W-1:0]         tmo_cycles,
   input  logic [DATA_W-1:0]        mon_tdata,
   input  logic                     mon_tvalid,
   input  logic                     mon_tready,
   input  logic                     mon_tlast,
   output logic [NUM_PAT*CNT_W-1:0] match_cnt,
   output logic [CNT_W-1:0]         unmatched_cnt,
   output logic                     busy,
   output logic                     done,
   output logic                     pass,
   output logic                     timeout
);

   state_t             state_q;
   logic [TMO_W-1:0]   timer_q;
   logic               sop_q;
   logic               sop_hit_q;
   logic               pass_q;
   logic               timeout_q;
   logic [NUM_PAT-1:0] hit_vec;
   logic [NUM_PAT-1:0] sat_vec;

   logic acc, armed, start, all_sat, expire, run, cfg_ok;

   assign acc     = mon_tvalid && mon_tready;
   assign armed   = (state_q == ST_ARMED);
   assign start   = arm && !abort && !armed;
   assign all_sat = &sat_vec;
   // The timer is loaded with the budget and the run ends on the cycle it
   // shows 1, so tmo_cycles=N gives N ARMED cycles (0 behaves like 1).
   assign expire  = (timer_q <= TMO_W'(1));
   // True only on ARMED cycles that stay ARMED; beats in flight when the run ends are dropped.
   assign run     = armed && !abort && !all_sat && !expire;
   assign cfg_ok  = cfg_wr && !armed;

   for (genvar i = 0; i < NUM_PAT; i++) begin : g_slot
      axis_match_slot #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_slot (
         .axis_aclk  (axis_aclk),
         .axis_rst   (axis_rst),
         .cfg_wr     (cfg_ok && (cfg_idx == IDX_W'(i))),
         .cfg_en     (cfg_en),
         .cfg_value  (cfg_value),
         .cfg_mask   (cfg_mask),
         .cfg_expect (cfg_expect),
         .tdata      (mon_tdata),
         .sample     (run && acc && sop_q),
         .run        (run),
         .clear      (start),
         .hit        (hit_vec[i]),
         .match_cnt  (match_cnt[i*CNT_W +: CNT_W]),
         .satisfied  (sat_vec[i])
      );
   end

   // Run control; abort has priority, pass beats timeout when both land together.
   always_ff @(posedge axis_aclk or posedge axis_rst) begin
      if (axis_rst || abort) begin
         state_q   <= ST_IDLE;
         pass_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else if (start) begin
         state_q   <= ST_ARMED;
         pass_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else if (armed) begin
         if (all_sat) begin
            state_q <= ST_DONE;
            pass_q  <= 1'b1;
         end else if (expire) begin
            state_q   <= ST_DONE;
            timeout_q <= 1'b1;
         end
      end
   end

   // Run budget down-counter.
   always_ff @(posedge axis_aclk or posedge axis_rst) begin
      if (axis_rst)   timer_q <= '0;
      else if (start) timer_q <= tmo_cycles;
      else if (run)   timer_q <= timer_q - TMO_W'(1);
   end

   // Start-of-packet tracker, independent of run state.
   always_ff @(posedge axis_aclk or posedge axis_rst) begin
      if (axis_rst) sop_q <= 1'b1;
      else if (acc) sop_q <= mon_tlast;
   end

   // Stage 1 companion of the slot compares: an SOP beat entered the pipe.
   always_ff @(posedge axis_aclk or posedge axis_rst) begin
      if (axis_rst) sop_hit_q <= 1'b0;
      else          sop_hit_q <= run && acc && sop_q;
   end

   // Stage 2 unmatched count: SOP beat that no enabled slot claimed.
   always_ff @(posedge axis_aclk or posedge axis_rst) begin
      if (axis_rst)
         unmatched_cnt <= '0;
      else if (start)
         unmatched_cnt <= '0;
      else if (run && sop_hit_q && !(|hit_vec))
         unmatched_cnt <= CNT_W'(sat_inc(32'(unmatched_cnt), CNT_W));
   end

   assign busy    = armed;
   assign done    = (state_q == ST_DONE);
   assign pass    = pass_q;
   assign timeout = timeout_q;

endmodule

// File: tb/tb_axis_match_monitor.sv
// Directed and randomized checks of axis_match_monitor against a packet-level model.
module tb_axis_match_monitor;

   localparam int DW = 64;
   localparam int NP = 4;
   localparam int CW = 8;
   localparam int TW = 24;
   localparam logic [DW-1:0] SUB       = 64'h5355_4200_0000_0001;
   localparam logic [DW-1:0] ADD       = 64'h4144_4400_0000_0002;
   localparam logic [DW-1:0] FULL      = '1;
   localparam logic [DW-1:0] RES_MASK  = 64'hFFFF_FFFF_0000_0000;

   logic             clk = 1'b0;
   logic             rst;
   logic             cfg_wr, cfg_en, arm, abort;
   logic [1:0]       cfg_idx;
   logic [DW-1:0]    cfg_value, cfg_mask, mon_tdata;
   logic [CW-1:0]    cfg_expect;
   logic [TW-1:0]    tmo_cycles;
   logic             mon_tvalid, mon_tready, mon_tlast;
   logic [NP*CW-1:0] match_cnt;
   logic [CW-1:0]    unmatched_cnt;
   logic             busy, done, pass, timeout;

   int checks = 0;
   int errors = 0;

   // Packet-level reference state for the randomized phase.
   logic [DW-1:0] mv [NP];
   logic [DW-1:0] mm [NP];
   logic          me [NP];
   int            exp_cnt [NP];
   int            exp_unm;

   always #5 clk = ~clk;

   axis_match_monitor #(.DATA_W(DW), .NUM_PAT(NP), .CNT_W(CW), .TMO_W(TW)) dut (
      .axis_aclk     (clk),
      .axis_rst      (rst),
      .cfg_wr        (cfg_wr),
      .cfg_idx       (cfg_idx),
      .cfg_en        (cfg_en),
      .cfg_value     (cfg_value),
      .cfg_mask      (cfg_mask),
      .cfg_expect    (cfg_expect),
      .arm           (arm),
      .abort         (abort),
      .tmo_cycles    (tmo_cycles),
      .mon_tdata     (mon_tdata),
      .mon_tvalid    (mon_tvalid),
      .mon_tready    (mon_tready),
      .mon_tlast     (mon_tlast),
      .match_cnt     (match_cnt),
      .unmatched_cnt (unmatched_cnt),
      .busy          (busy),
      .done          (done),
      .pass          (pass),
      .timeout       (timeout)
   );

   function automatic logic [CW-1:0] mcnt(input int i);
      return match_cnt[i*CW +: CW];
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_slot(input int idx, input logic en, input logic [DW-1:0] v,
                           input logic [DW-1:0] m, input logic [CW-1:0] e);
      cfg_wr = 1'b1; cfg_idx = idx[1:0]; cfg_en = en;
      cfg_value = v; cfg_mask = m; cfg_expect = e;
      tick();
      cfg_wr = 1'b0;
   endtask

   task automatic do_arm(input logic [TW-1:0] t);
      tmo_cycles = t; arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic do_abort();
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   task automatic beat(input logic [DW-1:0] d, input logic l);
      mon_tdata = d; mon_tlast = l; mon_tvalid = 1'b1; mon_tready = 1'b1;
      tick();
      mon_tvalid = 1'b0;
   endtask

   function automatic logic [DW-1:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   // Reference classification of one first beat.
   task automatic model_sop(input logic [DW-1:0] d);
      int nhit;
      nhit = 0;
      for (int i = 0; i < NP; i++) begin
         if (me[i] && (((d ^ mv[i]) & mm[i]) == '0)) begin
            nhit++;
            if (exp_cnt[i] < 255) exp_cnt[i]++;
         end
      end
      if (nhit == 0 && exp_unm < 255) exp_unm++;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit, observed running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] d;
      int len, k;

      rst = 1'b1; cfg_wr = 1'b0; cfg_idx = '0; cfg_en = 1'b0; cfg_value = '0;
      cfg_mask = '0; cfg_expect = '0; arm = 1'b0; abort = 1'b0; tmo_cycles = '0;
      mon_tdata = '0; mon_tvalid = 1'b0; mon_tready = 1'b1; mon_tlast = 1'b0;
      tick(); tick();
      rst = 1'b0;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_pass", pass, 0);
      check("rst_timeout", timeout, 0);
      check("rst_match_cnt", match_cnt, 0);
      check("rst_unmatched", unmatched_cnt, 0);

      // Single SUB packet against slot 0; done three cycles after the beat.
      cfg_slot(0, 1'b1, SUB, FULL, 1);
      do_arm(1000);
      check("t1_busy", busy, 1);
      beat(SUB, 1'b1);
      tick();
      check("t1_cnt0", mcnt(0), 1);
      check("t1_done_early", done, 0);
      tick();
      check("t1_done", done, 1);
      check("t1_pass", pass, 1);
      check("t1_timeout", timeout, 0);

      // Two slots, pass only after both packets.
      cfg_slot(1, 1'b1, ADD, FULL, 1);
      do_arm(1000);
      check("t2_cleared", mcnt(0), 0);
      beat(ADD, 1'b1);
      tick(); tick();
      check("t2_cnt1", mcnt(1), 1);
      check("t2_not_done", done, 0);
      repeat (3) tick();
      check("t2_still_busy", busy, 1);
      beat(SUB, 1'b1);
      tick(); tick();
      check("t2_done", done, 1);
      check("t2_pass", pass, 1);
      check("t2_unmatched", unmatched_cnt, 0);

      // SUB on a non-first beat must not count.
      cfg_slot(1, 1'b0, ADD, FULL, 1);
      do_arm(1000);
      beat(ADD, 1'b0);
      beat(SUB, 1'b0);
      beat(ADD, 1'b1);
      tick(); tick();
      check("t3_cnt0", mcnt(0), 0);
      check("t3_unmatched", unmatched_cnt, 1);
      check("t3_busy", busy, 1);

      // Timeout with no traffic.
      do_abort();
      do_arm(100);
      repeat (99) tick();
      check("t4_done_99", done, 0);
      tick();
      check("t4_done_100", done, 1);
      check("t4_timeout", timeout, 1);
      check("t4_pass", pass, 0);
      do_arm(0);
      check("t4z_busy", busy, 1);
      tick();
      check("t4z_timeout", timeout, 1);
      // Completion on the expiry cycle: pass wins.
      do_arm(10);
      repeat (7) tick();
      beat(SUB, 1'b1);
      tick(); tick();
      check("t4p_done", done, 1);
      check("t4p_pass", pass, 1);
      check("t4p_timeout", timeout, 0);
      // One cycle too late: in-flight beat discarded.
      do_arm(10);
      repeat (8) tick();
      beat(SUB, 1'b1);
      tick();
      check("t4l_timeout", timeout, 1);
      check("t4l_pass", pass, 0);
      check("t4l_cnt0", mcnt(0), 0);

      // Result bytes masked off; stalled beats are not accepted.
      cfg_slot(0, 1'b1, SUB, RES_MASK, 5);
      do_arm(1000);
      mon_tdata = SUB; mon_tlast = 1'b1; mon_tvalid = 1'b1; mon_tready = 1'b0;
      repeat (5) tick();
      mon_tvalid = 1'b0; mon_tready = 1'b1;
      tick(); tick();
      check("t5_stall_cnt", mcnt(0), 0);
      check("t5_stall_unm", unmatched_cnt, 0);
      for (int n = 0; n < 5; n++) begin
         d = SUB;
         d[31:0] = $urandom;
         beat(d, 1'b1);
      end
      tick(); tick();
      check("t5_cnt0", mcnt(0), 5);
      check("t5_pass", pass, 1);

      // Unmatched saturation and dropped slot writes while armed.
      cfg_slot(0, 1'b1, SUB, FULL, 1);
      do_arm(5000);
      repeat (260) beat(ADD, 1'b1);
      tick(); tick();
      check("t6_unm_sat", unmatched_cnt, 255);
      check("t6_busy", busy, 1);
      cfg_slot(0, 1'b1, ADD, FULL, 1);
      beat(SUB, 1'b1);
      tick(); tick();
      check("t6_cfg_drop_cnt", mcnt(0), 1);
      check("t6_cfg_drop_pass", pass, 1);

      // Abort holds counters; idle traffic is not counted; abort beats arm.
      cfg_slot(0, 1'b1, SUB, FULL, 3);
      do_arm(1000);
      beat(SUB, 1'b1);
      beat(ADD, 1'b1);
      tick(); tick();
      check("t7_cnt0", mcnt(0), 1);
      do_abort();
      check("t7_busy", busy, 0);
      check("t7_done", done, 0);
      check("t7_held_cnt", mcnt(0), 1);
      check("t7_held_unm", unmatched_cnt, 1);
      beat(SUB, 1'b1);
      tick(); tick();
      check("t7_idle_cnt", mcnt(0), 1);
      abort = 1'b1; arm = 1'b1;
      tick();
      abort = 1'b0; arm = 1'b0;
      check("t7_abort_wins", busy, 0);
      do_arm(1000);
      beat(SUB, 1'b1);
      do_abort();
      tick();
      check("t7_inflight", mcnt(0), 0);

      // Randomized traffic against the packet-level model.
      for (int i = 0; i < NP; i++) begin
         mv[i] = rnd64();
         mm[i] = rnd64();
         me[i] = (i != 3);
         exp_cnt[i] = 0;
      end
      mv[1] = mv[0];
      mm[1] = mm[0] & rnd64();
      exp_unm = 0;
      for (int i = 0; i < NP; i++) cfg_slot(i, me[i], mv[i], mm[i], 200);
      do_arm(20000);
      for (int p = 0; p < 40; p++) begin
         len = $urandom_range(1, 3);
         k = $urandom_range(0, 4);
         if (k < 4) d = (mv[k] & mm[k]) | (rnd64() & ~mm[k]);
         else       d = rnd64();
         model_sop(d);
         for (int b = 0; b < len; b++) begin
            if ($urandom_range(0, 3) == 0) begin
               mon_tdata = rnd64(); mon_tvalid = 1'b1; mon_tready = 1'b0;
               tick();
               mon_tvalid = 1'b0; mon_tready = 1'b1;
            end
            beat((b == 0) ? d : rnd64(), (b == len - 1));
         end
      end
      tick(); tick();
      for (int i = 0; i < NP; i++) check($sformatf("rnd_cnt%0d", i), mcnt(i), exp_cnt[i]);
      check("rnd_unmatched", unmatched_cnt, exp_unm);
      check("rnd_busy", busy, 1);

      // Reset mid-packet, then zero-slot run and SOP restart.
      beat(rnd64(), 1'b0);
      rst = 1'b1;
      #2;
      check("t9_busy", busy, 0);
      check("t9_done", done, 0);
      check("t9_pass", pass, 0);
      check("t9_timeout", timeout, 0);
      check("t9_match_cnt", match_cnt, 0);
      check("t9_unmatched", unmatched_cnt, 0);
      tick();
      rst = 1'b0;
      do_arm(1000);
      tick();
      check("t9_zero_slot_pass", pass, 1);
      check("t9_zero_slot_done", done, 1);
      cfg_slot(0, 1'b1, SUB, FULL, 1);
      do_arm(1000);
      beat(SUB, 1'b1);
      tick(); tick();
      check("t9_sop_cnt", mcnt(0), 1);
      check("t9_sop_pass", pass, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
